// File: rtl/pkt_sink_ni.sv
// Network-interface sink: accepts 4-phase bundled-data packets, filters on destination, buffers payloads in a FWFT FIFO.
// Latency: in_req rise -> in_ack/push in 4 edges with PKT_SINK_SYNC_EN defined, 3 edges without; FIFO head visible the cycle after push.
// Backpressure: full FIFO parks a matching packet in HOLD with in_ack low until a slot frees; consumer side is valid/ready.
// Optional: PKT_SINK_SYNC_EN selects a 2-flop in_req synchronizer (default: single sampling register).
module pkt_sink_ni #(
    parameter logic [3:0] NODE_ADDR = 4'h0,
    parameter int         DEPTH     = 4,
    parameter int         CNT_W     = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_req,
    input  logic [32:0]              in_data,
    output logic                     in_ack,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [23:0]              out_data,
    output logic [3:0]               out_src,
    output logic                     out_type,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic [CNT_W-1:0]         drop_cnt
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LW = $clog2(DEPTH) + 1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CAPTURE  = 2'd1,
        HOLD     = 2'd2,
        WAIT_LOW = 2'd3
    } state_t;

    state_t        state, state_n;
    logic          ack_n;
    logic          push;
    logic          pop;
    logic          drop_inc;
    logic          match;
    logic          full;
    logic          req_s;
    logic [28:0]   cap_q;
    logic [28:0]   wr_entry;
    logic [28:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

`ifdef PKT_SINK_SYNC_EN
    logic req_meta;

    // Two-flop synchronizer: in_req is asynchronous to clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_meta <= 1'b0;
            req_s    <= 1'b0;
        end else begin
            req_meta <= in_req;
            req_s    <= req_meta;
        end
    end
`else
    // Single sampling register; only safe with clock-aligned stimulus.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_s <= 1'b0;
        end else begin
            req_s <= in_req;
        end
    end
`endif

    assign match    = (in_data[32:29] == NODE_ADDR) || (in_data[32:29] == 4'hF);
    assign full     = (fifo_level == LW'(DEPTH));
    assign pop      = (fifo_level != '0) && out_ready;
    // In CAPTURE the bundled data is still stable, so it feeds the FIFO directly;
    // HOLD pushes the copy taken during CAPTURE.
    assign wr_entry = (state == HOLD) ? cap_q : in_data[28:0];

    // Next-state and handshake decisions; full is the occupancy at cycle start,
    // so a same-cycle pop never makes room for this cycle's push.
    always_comb begin
        state_n  = state;
        ack_n    = in_ack;
        push     = 1'b0;
        drop_inc = 1'b0;
        case (state)
            IDLE: begin
                if (req_s) state_n = CAPTURE;
            end
            CAPTURE: begin
                if (match) begin
                    if (!full) begin
                        push    = 1'b1;
                        ack_n   = 1'b1;
                        state_n = WAIT_LOW;
                    end else begin
                        state_n = HOLD;
                    end
                end else begin
                    drop_inc = 1'b1;
                    ack_n    = 1'b1;
                    state_n  = WAIT_LOW;
                end
            end
            HOLD: begin
                if (!full) begin
                    push    = 1'b1;
                    ack_n   = 1'b1;
                    state_n = WAIT_LOW;
                end
            end
            WAIT_LOW: begin
                if (!req_s) begin
                    ack_n   = 1'b0;
                    state_n = IDLE;
                end
            end
            default: begin
                ack_n   = 1'b0;
                state_n = IDLE;
            end
        endcase
    end

    // FSM state and registered acknowledge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            in_ack <= 1'b0;
        end else begin
            state  <= state_n;
            in_ack <= ack_n;
        end
    end

    // Packet capture register, loaded only while the request is being serviced.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_q <= '0;
        end else if (state == CAPTURE) begin
            cap_q <= in_data[28:0];
        end
    end

    // Saturating count of packets dropped for address mismatch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt <= '0;
        end else if (drop_inc && (drop_cnt != '1)) begin
            drop_cnt <= drop_cnt + CNT_W'(1);
        end
    end

    // FIFO storage and pointers; power-of-two depth lets pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wr_entry;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + LW'(1);
                2'b01:   fifo_level <= fifo_level - LW'(1);
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    assign out_valid = (fifo_level != '0);
    assign out_data  = mem[rd_ptr][23:0];
    assign out_type  = mem[rd_ptr][24];
    assign out_src   = mem[rd_ptr][28:25];

endmodule

// File: doc/pkt_sink_ni.md
Name: pkt_sink_ni

Overview:
- Clocked network-interface sink that sits directly downstream of Pkt_PE.
- Consumes the 33-bit packets Pkt_PE emits on its 4-phase bundled-data channel.
- Checks the destination address, buffers accepted payloads in a small FWFT FIFO and presents them on a synchronous valid/ready port to the local compute element.
- Acts as the asynchronous-to-synchronous bridge between the CSP packet network and clocked PE logic.

Parameters:
- NODE_ADDR, 4'h0, this node's address; compared against packet bits [32:29].
- DEPTH, 4, payload FIFO entries; power of two, 2..16.
- CNT_W, 8, width of the saturating drop counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_req  input  1  4-phase request from Pkt_PE; asynchronous to clk.
- in_data  input  33  packet: [32:29] dst, [28:25] src, [24] type, [23:0] payload; stable while in_req=1.
- in_ack  output  1  4-phase acknowledge, registered.
- out_valid  output  1  FIFO head valid (FIFO not empty).
- out_ready  input  1  consumer accepts head on a clk edge where out_valid&out_ready.
- out_data  output  24  head payload.
- out_src  output  4  head source address.
- out_type  output  1  head type bit.
- fifo_level  output  $clog2(DEPTH)+1  current occupancy.
- drop_cnt  output  CNT_W  count of packets discarded for address mismatch; saturates at all-ones.

Behaviour:
- Reset (async assert, sync release): in_ack=0, out_valid=0, out_data/out_src/out_type=0, fifo_level=0, drop_cnt=0, FSM=IDLE, synchronizer flops=0. Reset mid-handshake drops in_ack immediately; any packet being captured is lost.
- in_req passes through a 2-flop synchronizer to give req_s (see optional feature).
- FSM states: IDLE, CAPTURE, HOLD, WAIT_LOW.
  - IDLE: req_s=1 -> CAPTURE.
  - CAPTURE: register in_data. Then evaluate:
    - match = (dst==NODE_ADDR) or (dst==4'hF, broadcast).
    - match and FIFO not full: push, raise in_ack, go to WAIT_LOW.
    - match and FIFO full: go to HOLD with in_ack=0 (backpressure).
    - mismatch: drop_cnt+1 (saturating), raise in_ack, go to WAIT_LOW.
  - HOLD: each cycle, if FIFO not full, push the captured packet, raise in_ack, go to WAIT_LOW.
  - WAIT_LOW: hold in_ack=1 until req_s=0; then in_ack<=0, go to IDLE.
- Push is evaluated against occupancy at the start of the cycle. A same-cycle pop does not free space for a push, so a full FIFO pushes at the earliest one cycle after a pop.
- FIFO is first-word-fall-through. out_* reflect the head combinationally from registered storage. Pop on out_valid&out_ready. Read and write pointers wrap modulo DEPTH. Pop while empty is ignored. Simultaneous push and pop with 0<level<DEPTH leaves level unchanged.
- Latency with synchronizer:
  - in_req rise is first sampled at edge E0; req_s=1 after E1; CAPTURE at E2; in_ack=1 and push at E3.
  - For a push into an empty FIFO, out_valid=1 after E3.
  - in_ack falls 3 edges after in_req falls is first sampled.
- in_data is captured only in CAPTURE or HOLD and never while in_req=0.
- A new in_req rise is ignored until the FSM has returned to IDLE.

Optional Feature:
- Macro PKT_SINK_SYNC_EN.
- Defined: 2-flop synchronizer on in_req, latency as above. Required when Pkt_PE is truly asynchronous.
- Undefined: req_s = in_req sampled by a single register. All handshake latencies shrink by one cycle. Only for simulation with clock-aligned CSP stimulus.

Test Plan:
- Single match: NODE_ADDR=3; send {4'h3,4'h5,1'b0,24'h000001} -> in_ack rises 4 edges after req is first sampled; out_valid=1, out_data=24'h000001, out_src=5, drop_cnt=0; full 4-phase cycle completes.
- Mismatch and broadcast: send dst=4'h7, then dst=4'hF -> first is acked with drop_cnt=1 and no push; second is pushed with fifo_level=1.
- Backpressure: out_ready=0; send DEPTH+1=5 matching packets -> first 4 acked and fifo_level=4; 5th holds in_ack=0. Pulse out_ready for one cycle -> 5th is pushed and acked one cycle later; fifo_level stays 4; order preserved (payloads 1..5).
- Simultaneous push/pop: level=2, out_ready=1 during push -> level stays 2 and FIFO order is correct.
- Drop saturation: CNT_W=2; send 5 mismatching packets -> drop_cnt=3.
- Reset mid-handshake: assert rst_n=0 while in WAIT_LOW with level=2 -> in_ack=0 immediately, level=0, out_valid=0. After release, a new packet is accepted normally.
